// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register offsets,
// STATUS bit positions and the serialiser state encoding.
package uart_pkg;

   localparam logic [1:0] UART_TXDATA = 2'd0;
   localparam logic [1:0] UART_STATUS = 2'd1;
   localparam logic [1:0] UART_DIV    = 2'd2;
   localparam logic [1:0] UART_CTRL   = 2'd3;

   localparam int unsigned ST_FULL    = 0;
   localparam int unsigned ST_EMPTY   = 1;
   localparam int unsigned ST_BUSY    = 2;
   localparam int unsigned ST_OVF     = 3;
   localparam int unsigned ST_CNT_LSB = 8;

   localparam int unsigned CTRL_TX_EN  = 0;
   localparam int unsigned CTRL_IRQ_EN = 1;

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } uart_state_e;

   // Builds the low half of the STATUS word; upper bits are always zero.
   function automatic logic [15:0] pack_status(input logic       full,
                                               input logic       empty,
                                               input logic       busy,
                                               input logic       ovf,
                                               input logic [3:0] count);
      logic [15:0] word;
      word                     = '0;
      word[ST_FULL]            = full;
      word[ST_EMPTY]           = empty;
      word[ST_BUSY]            = busy;
      word[ST_OVF]             = ovf;
      word[ST_CNT_LSB +: 4]    = count;
      return word;
   endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte-wide synchronous FIFO holding pending TX characters; Depth must be a
// power of two so the pointers wrap naturally.
module uart_tx_fifo #(
   parameter int unsigned Depth = 8
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     push,
   input  logic [7:0]               wdata,
   input  logic                     pop,
   output logic [7:0]               rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(Depth):0]   count
);

   localparam int unsigned PtrW = $clog2(Depth);
   localparam int unsigned CntW = PtrW + 1;

   logic [7:0]      mem_q [Depth];
   logic [PtrW-1:0] wptr_q;
   logic [PtrW-1:0] rptr_q;
   logic [CntW-1:0] count_q;
   logic            do_push;
   logic            do_pop;

   assign full    = (count_q == CntW'(Depth));
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign rdata   = mem_q[rptr_q];

   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;

   always_ff @(posedge clk_i) begin
      if (do_push) begin
         mem_q[wptr_q] <= wdata;
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         if (do_push) begin
            wptr_q <= wptr_q + PtrW'(1);
         end
         if (do_pop) begin
            rptr_q <= rptr_q + PtrW'(1);
         end
         unique case ({do_push, do_pop})
            2'b10:   count_q <= count_q + CntW'(1);
            2'b01:   count_q <= count_q - CntW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/uart_tx.sv
// Memory-mapped 8N1 UART transmitter: bus register file, TX FIFO, bit-period
// serialiser and a level TX-empty interrupt.
module uart_tx
   import uart_pkg::*;
#(
   parameter int unsigned DataWidth  = 32,
   parameter int unsigned AddrWidth  = 32,
   parameter int unsigned FifoDepth  = 8,
   parameter logic [15:0] DefaultDiv = 16'd433
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 req_i,
   input  logic                 we_i,
   input  logic [AddrWidth-1:0] addr_i,
   input  logic [DataWidth-1:0] data_i,
   output logic [DataWidth-1:0] data_o,
   output logic                 tx_o,
   output logic                 irq_o
);

   localparam int unsigned CntW = $clog2(FifoDepth) + 1;

   logic [1:0]           reg_sel;
   logic                 wr;
   logic                 rd;

   logic [15:0]          div_q;
   logic                 tx_en_q;
   logic                 irq_en_q;
   logic                 ovf_q;
   logic [DataWidth-1:0] rdata_q;
   logic [DataWidth-1:0] rdata;
   logic                 irq_q;

   logic                 fifo_push;
   logic                 fifo_pop;
   logic [7:0]           fifo_head;
   logic                 fifo_full;
   logic                 fifo_empty;
   logic [CntW-1:0]      fifo_count;

   uart_state_e          state_q;
   logic                 tx_q;
   logic [15:0]          tick_q;
   logic [15:0]          reload_q;
   logic [2:0]           bit_idx_q;
   logic [7:0]           shift_q;
   logic                 bit_end;
   logic                 frame_start;
   logic                 busy;

   logic                 unused_bits;
   assign unused_bits = ^{addr_i[AddrWidth-1:4], addr_i[1:0], data_i[DataWidth-1:16]};

   assign reg_sel = addr_i[3:2];
   assign wr      = req_i & we_i;
   assign rd      = req_i & ~we_i;

   // Writes while full are dropped; the FIFO state at cycle start decides.
   assign fifo_push = wr & (reg_sel == UART_TXDATA) & ~fifo_full;

   uart_tx_fifo #(
      .Depth (FifoDepth)
   ) u_fifo (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .push  (fifo_push),
      .wdata (data_i[7:0]),
      .pop   (fifo_pop),
      .rdata (fifo_head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         div_q    <= DefaultDiv;
         tx_en_q  <= 1'b0;
         irq_en_q <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         if (wr) begin
            unique case (reg_sel)
               UART_TXDATA: begin
                  if (fifo_full) begin
                     ovf_q <= 1'b1;
                  end
               end
               UART_DIV:  div_q <= data_i[15:0];
               UART_CTRL: begin
                  tx_en_q  <= data_i[CTRL_TX_EN];
                  irq_en_q <= data_i[CTRL_IRQ_EN];
               end
               default: ;
            endcase
         end else if (rd && (reg_sel == UART_STATUS)) begin
            ovf_q <= 1'b0;
         end
      end
   end

   assign busy = (state_q != IDLE);

   always_comb begin
      rdata = '0;
      unique case (reg_sel)
         UART_STATUS: rdata[15:0] = pack_status(fifo_full, fifo_empty, busy, ovf_q,
                                                4'(fifo_count));
         UART_DIV:    rdata[15:0] = div_q;
         UART_CTRL:   rdata[1:0]  = {irq_en_q, tx_en_q};
         default:     rdata       = '0;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         rdata_q <= '0;
      end else if (rd) begin
         rdata_q <= rdata;
      end
   end

   assign bit_end     = (tick_q == '0);
   // A new frame starts from IDLE or straight out of the last STOP clock.
   assign frame_start = tx_en_q & ~fifo_empty &
                        ((state_q == IDLE) | ((state_q == STOP) & bit_end));
   assign fifo_pop    = frame_start;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q   <= IDLE;
         tx_q      <= 1'b1;
         tick_q    <= '0;
         reload_q  <= '0;
         bit_idx_q <= '0;
         shift_q   <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (frame_start) begin
                  state_q  <= START;
                  tx_q     <= 1'b0;
                  shift_q  <= fifo_head;
                  reload_q <= div_q;
                  tick_q   <= div_q;
               end
            end
            START: begin
               if (bit_end) begin
                  state_q   <= DATA;
                  tx_q      <= shift_q[0];
                  shift_q   <= shift_q >> 1;
                  bit_idx_q <= '0;
                  tick_q    <= reload_q;
               end else begin
                  tick_q <= tick_q - 16'd1;
               end
            end
            DATA: begin
               if (bit_end) begin
                  tick_q <= reload_q;
                  if (bit_idx_q == 3'd7) begin
                     state_q <= STOP;
                     tx_q    <= 1'b1;
                  end else begin
                     tx_q      <= shift_q[0];
                     shift_q   <= shift_q >> 1;
                     bit_idx_q <= bit_idx_q + 3'd1;
                  end
               end else begin
                  tick_q <= tick_q - 16'd1;
               end
            end
            STOP: begin
               if (bit_end) begin
                  if (frame_start) begin
                     state_q  <= START;
                     tx_q     <= 1'b0;
                     shift_q  <= fifo_head;
                     reload_q <= div_q;
                     tick_q   <= div_q;
                  end else begin
                     state_q <= IDLE;
                  end
               end else begin
                  tick_q <= tick_q - 16'd1;
               end
            end
            default: begin
               state_q <= IDLE;
               tx_q    <= 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         irq_q <= 1'b0;
      end else begin
         irq_q <= irq_en_q & fifo_empty & (state_q == IDLE);
      end
   end

   assign data_o = rdata_q;
   assign tx_o   = tx_q;
   assign irq_o  = irq_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: a frame-timeline reference model checked every
// cycle, plus hand-computed expectations for the key scenarios.
module tb_uart_tx;

   localparam int unsigned Depth  = 8;
   localparam logic [15:0] DefDiv = 16'd433;
   localparam logic [31:0] Base   = 32'h1000_0000;

   logic        clk_i  = 1'b0;
   logic        rst_i  = 1'b0;
   logic        req_i  = 1'b0;
   logic        we_i   = 1'b0;
   logic [31:0] addr_i = '0;
   logic [31:0] data_i = '0;
   logic [31:0] data_o;
   logic        tx_o;
   logic        irq_o;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   uart_tx #(
      .DataWidth  (32),
      .AddrWidth  (32),
      .FifoDepth  (Depth),
      .DefaultDiv (DefDiv)
   ) dut (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .req_i  (req_i),
      .we_i   (we_i),
      .addr_i (addr_i),
      .data_i (data_i),
      .data_o (data_o),
      .tx_o   (tx_o),
      .irq_o  (irq_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got 0x%08h, expected 0x%08h", name, cyc, act, exp);
      end
   endtask

   // Reference model: a queue of pending bytes and a frame timeline where the
   // line level is looked up from the position inside a 10-slot frame.
   logic [7:0]  mq[$];
   int unsigned m_div    = DefDiv;
   bit          m_tx_en  = 0;
   bit          m_irq_en = 0;
   bit          m_ovf    = 0;
   bit          m_active = 0;
   int unsigned m_pos    = 0;
   int unsigned m_period = 1;
   logic [7:0]  m_byte   = '0;
   logic        exp_tx    = 1'b1;
   logic        exp_irq   = 1'b0;
   logic [31:0] exp_rdata = '0;

   function automatic logic frame_bit(input int unsigned pos, input int unsigned period,
                                      input logic [7:0] b);
      int unsigned slot;
      slot = pos / period;
      if (slot == 0) return 1'b0;
      if (slot == 9) return 1'b1;
      return b[slot-1];
   endfunction

   task automatic model_step();
      int unsigned cnt;
      int unsigned old_div;
      bit          ending;
      bit          start;
      logic [7:0]  popped;
      if (rst_i !== 1'b1) begin
         mq.delete();
         m_div = DefDiv; m_tx_en = 0; m_irq_en = 0; m_ovf = 0;
         m_active = 0; m_pos = 0; m_period = 1; m_byte = '0;
         exp_tx = 1'b1; exp_irq = 1'b0; exp_rdata = '0;
         return;
      end
      cnt     = mq.size();
      old_div = m_div;
      popped  = '0;
      ending  = m_active && (m_pos == 10 * m_period - 1);
      start   = m_tx_en && (cnt > 0) && (!m_active || ending);
      exp_irq = m_irq_en && (cnt == 0) && !m_active;
      if (req_i && !we_i) begin
         case (addr_i[3:2])
            2'd1: begin
               exp_rdata = (32'(cnt) << 8) | (32'(m_ovf) << 3) | (32'(m_active) << 2) |
                           (32'(cnt == 0) << 1) | 32'(cnt == Depth);
               m_ovf = 0;
            end
            2'd2:    exp_rdata = 32'(m_div);
            2'd3:    exp_rdata = {30'd0, m_irq_en, m_tx_en};
            default: exp_rdata = '0;
         endcase
      end
      if (start) popped = mq.pop_front();
      if (req_i && we_i) begin
         case (addr_i[3:2])
            2'd0: begin
               if (cnt == Depth) m_ovf = 1;
               else mq.push_back(data_i[7:0]);
            end
            2'd2: m_div = data_i[15:0];
            2'd3: begin
               m_tx_en  = data_i[0];
               m_irq_en = data_i[1];
            end
            default: ;
         endcase
      end
      if (start) begin
         m_active = 1; m_pos = 0; m_period = old_div + 1; m_byte = popped;
      end else if (m_active) begin
         if (ending) m_active = 0;
         else m_pos++;
      end
      exp_tx = m_active ? frame_bit(m_pos, m_period, m_byte) : 1'b1;
   endtask

   initial forever begin
      @(posedge clk_i or negedge rst_i);
      model_step();
   end

   initial forever begin
      @(posedge clk_i);
      cyc++;
   end

   initial forever begin
      @(negedge clk_i);
      if (rst_i === 1'b1) begin
         check("tx_model", {31'd0, tx_o}, {31'd0, exp_tx});
         check("irq_model", {31'd0, irq_o}, {31'd0, exp_irq});
         check("rdata_model", data_o, exp_rdata);
      end
   end

   // Cycle stamps of line transitions, used to measure bit and frame lengths.
   int   falls[$];
   int   rises[$];
   logic prev_tx = 1'b1;
   initial forever begin
      @(negedge clk_i);
      if (prev_tx === 1'b1 && tx_o === 1'b0) falls.push_back(cyc);
      if (prev_tx === 1'b0 && tx_o === 1'b1) rises.push_back(cyc);
      prev_tx = tx_o;
   end

   task automatic bus_write(input logic [1:0] idx, input logic [31:0] val);
      @(negedge clk_i);
      req_i = 1'b1; we_i = 1'b1; addr_i = Base | {28'd0, idx, 2'b00}; data_i = val;
      @(negedge clk_i);
      req_i = 1'b0; we_i = 1'b0; data_i = '0;
   endtask

   task automatic bus_read(input logic [1:0] idx, output logic [31:0] val);
      @(negedge clk_i);
      req_i = 1'b1; we_i = 1'b0; addr_i = Base | {28'd0, idx, 2'b00};
      @(negedge clk_i);
      req_i = 1'b0;
      val = data_o;
   endtask

   task automatic do_reset();
      @(negedge clk_i);
      rst_i = 1'b0;
      repeat (2) @(negedge clk_i);
      rst_i = 1'b1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [31:0] rv;
      logic [9:0]  pat;
      repeat (3) @(negedge clk_i);
      rst_i = 1'b1;

      // Reset state
      check("reset_tx", {31'd0, tx_o}, 32'd1);
      check("reset_irq", {31'd0, irq_o}, 32'd0);
      bus_read(2'd1, rv); check("reset_status", rv, 32'h0000_0002);
      bus_read(2'd2, rv); check("reset_div", rv, 32'd433);
      bus_read(2'd0, rv); check("txdata_read", rv, 32'd0);

      // Single byte 0x55 at DIV=3
      bus_write(2'd2, 32'd3);
      bus_write(2'd3, 32'd1);
      bus_read(2'd3, rv); check("ctrl_read", rv, 32'd1);
      bus_write(2'd0, 32'h55);
      check("single_pre_edge", {31'd0, tx_o}, 32'd1);
      pat = 10'b10_1010_1010;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk_i);
         check($sformatf("single_bit%0d", i), {31'd0, tx_o}, {31'd0, pat[i/4]});
      end
      @(negedge clk_i);
      check("single_after", {31'd0, tx_o}, 32'd1);
      bus_read(2'd1, rv); check("single_status", rv, 32'h0000_0002);

      // Back-to-back frames at DIV=1
      do_reset();
      bus_write(2'd2, 32'd1);
      bus_write(2'd3, 32'd1);
      bus_write(2'd0, 32'hA5);
      bus_write(2'd0, 32'h3C);
      for (int i = 0; i < 18; i++) begin
         bus_read(2'd1, rv);
         check($sformatf("b2b_busy%0d", i), {31'd0, rv[2]}, 32'd1);
      end
      repeat (4) @(negedge clk_i);
      bus_read(2'd1, rv); check("b2b_status_done", rv, 32'h0000_0002);

      // Overflow with transmitter disabled
      do_reset();
      for (int i = 0; i < 9; i++) bus_write(2'd0, 32'(i + 8'h30));
      bus_read(2'd1, rv); check("ovf_status1", rv, 32'h0000_0809);
      bus_read(2'd1, rv); check("ovf_status2", rv, 32'h0000_0801);

      // DIV rewritten during DATA of the first frame
      do_reset();
      bus_write(2'd2, 32'd2);
      bus_write(2'd3, 32'd1);
      falls.delete(); rises.delete();
      bus_write(2'd0, 32'hFF);
      repeat (6) @(negedge clk_i);
      bus_write(2'd2, 32'd0);
      bus_write(2'd0, 32'hFF);
      repeat (40) @(negedge clk_i);
      if (falls.size() == 2 && rises.size() == 2) begin
         check("div_frame1_len", 32'(falls[1] - falls[0]), 32'd30);
         check("div_start1_len", 32'(rises[0] - falls[0]), 32'd3);
         check("div_start2_len", 32'(rises[1] - falls[1]), 32'd1);
      end else begin
         check("div_edge_count", 32'(falls.size()), 32'd2);
      end
      bus_read(2'd1, rv); check("div_status_done", rv, 32'h0000_0002);

      // IRQ behaviour, then reset in the middle of a frame
      do_reset();
      bus_write(2'd2, 32'd1);
      bus_write(2'd3, 32'd3);
      bus_write(2'd0, 32'h00);
      check("irq_before_frame", {31'd0, irq_o}, 32'd1);
      repeat (10) @(negedge clk_i);
      check("irq_mid_frame", {31'd0, irq_o}, 32'd0);
      repeat (11) @(negedge clk_i);
      check("irq_last_stop", {31'd0, irq_o}, 32'd0);
      @(negedge clk_i);
      check("irq_after_idle", {31'd0, irq_o}, 32'd1);
      bus_write(2'd0, 32'h00);
      repeat (5) @(negedge clk_i);
      check("rst_mid_low", {31'd0, tx_o}, 32'd0);
      #2;
      rst_i = 1'b0;
      #1;
      check("rst_mid_tx", {31'd0, tx_o}, 32'd1);
      check("rst_mid_irq", {31'd0, irq_o}, 32'd0);
      repeat (2) @(negedge clk_i);
      rst_i = 1'b1;
      bus_read(2'd1, rv); check("rst_mid_status", rv, 32'h0000_0002);
      repeat (3) @(negedge clk_i);
      check("rst_mid_tx_idle", {31'd0, tx_o}, 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
Memory-mapped UART transmitter, a bus device slave next to console and clint. It consumes device-side req/we/addr/wdata from the bus, buffers bytes in a TX FIFO, and serialises them as 8N1 frames on tx_o. It also supplies registered read data for its status/config registers and a level interrupt toward the core irq inputs.

Parameters:
DataWidth, 32, bus data width
AddrWidth, 32, bus address width
FifoDepth, 8, TX FIFO entries; power of 2, ≥2
DefaultDiv, 16'd433, reset value of DIV; bit period = DIV+1 clocks

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, asynchronous, active-low
req_i  in  1  bus device request
we_i  in  1  write enable (1=write)
addr_i  in  AddrWidth  byte address; only addr_i[3:2] decoded
data_i  in  DataWidth  write data
data_o  out  DataWidth  read data, registered
tx_o  out  1  serial output, idle high
irq_o  out  1  TX-empty interrupt, level, registered

Behaviour:
- Reset (rst_i=0, async): tx_o=1, data_o=0, irq_o=0, FIFO empty, FSM IDLE, DIV=DefaultDiv, CTRL=0, overflow=0.
- Register map (addr_i[3:2]):
  - 0 TXDATA (W): push data_i[7:0]; reads return 0.
  - 1 STATUS (R): [0] full, [1] empty, [2] busy (FSM≠IDLE), [3] overflow (sticky), [11:8] fifo count; other bits 0; writes ignored.
  - 2 DIV (RW): [15:0].
  - 3 CTRL (RW): [0] tx_en, [1] irq_en.
- Read: req_i & ~we_i at edge N → data_o valid after edge N, held until the next read. No wait states; read of STATUS clears overflow at the same edge; the returned value is the pre-clear value.
- Write: take effect at the edge where req_i & we_i is sampled.
- FIFO push on TXDATA write when not full at cycle start. A write while full is dropped and overflow is set, even if a pop happens in the same cycle.
- FIFO pop only when count>0 at cycle start; a push into an empty FIFO is not popped in the same cycle.
- FSM IDLE→START: when tx_en=1 and FIFO non-empty.
  - Pop the head into the shift register.
  - Latch DIV into the bit-period counter reload.
  - tx_o=0 from the same edge.
- START → DATA → STOP:
  - Each state lasts DIV_latched+1 clocks.
  - DATA shifts 8 bits LSB first; a 3-bit bit counter goes 0..7.
  - STOP drives tx_o=1 for one bit period.
- STOP end:
  - If tx_en & FIFO non-empty, go directly to START (no idle gap, new pop, new DIV latch).
  - Otherwise go to IDLE.
- Write to DIV mid-frame: no effect until the next START.
- tx_en cleared mid-frame: the current frame completes, then IDLE.
- Frame length: exactly 10×(DIV+1) clocks. DIV=0 is legal (1 clock per bit).
- irq_o registered = irq_en & FIFO empty & FSM IDLE.
- Reset asserted mid-frame: tx_o returns to 1 immediately (async); the partial frame is abandoned.
- Count width: $clog2(FifoDepth)+1, zero-extended into STATUS[11:8].

Decomposition:
- Shared package uart_pkg: register offsets (UART_TXDATA=2'd0, UART_STATUS=2'd1, UART_DIV=2'd2, UART_CTRL=2'd3), STATUS bit indices, FSM state enum {IDLE, START, DATA, STOP}.
- Sub-module uart_tx_fifo:
  - Synchronous FIFO with push/pop/full/empty/count, parameter Depth, width 8.
  - Same clk_i/rst_i.
  - Instantiated once.

Test Plan:
- Reset: after rst_i 0→1, tx_o=1, irq_o=0, read STATUS → 0x0000_0002 (empty), read DIV → DefaultDiv.
- Single byte: write DIV=3, CTRL=1, TXDATA=0x55 → tx_o falls one edge after the TXDATA write edge. Bits are 0,1,0,1,0,1,0,1,0,1, each held 4 clocks; 40 clocks total; then IDLE.
- Back-to-back: push 0xA5, 0x3C with DIV=1 → two frames of 20 clocks each with no gap; STATUS.busy=1 throughout, then STATUS=0x02.
- Overflow: tx_en=0, push 9 bytes with FifoDepth=8 → STATUS=0x0000_0809 (count 8, full, overflow). A second STATUS read returns 0x0000_0801.
- DIV change mid-frame: DIV=2, send 0xFF; write DIV=0 during DATA → first frame is 30 clocks, next frame is 10 clocks.
- IRQ / reset mid-frame: CTRL=3, send 0x00 → irq_o=0 during the frame and 1 one edge after return to IDLE. Assert rst_i mid-frame in a second send → tx_o=1 and irq_o=0 immediately, FIFO empty.
